// File: rtl/amo_unit.sv
// rtl/amo_unit.sv - RV64A AMO read-modify-write responder; LR/SC built only with AMO_LRSC_EN
module amo_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            amo_req,
    input  logic [4:0]      amo_funct5,
    input  logic [2:0]      amo_funct3,
    input  logic [XLEN-1:0] amo_addr,
    input  logic [XLEN-1:0] amo_src,
    output logic [XLEN-1:0] amo_rd,
    output logic            amo_ack,
    output logic            amo_err,
    output logic [XLEN-1:0] b_addr,
    output logic            b_rd,
    output logic            b_wr,
    output logic [7:0]      b_be,
    output logic [XLEN-1:0] b_data_w,
    input  logic [XLEN-1:0] b_data_r,
    input  logic            b_ack,
    input  logic            snp_wr,
    input  logic [XLEN-1:0] snp_addr
);

    localparam logic [4:0] F5_ADD  = 5'b00000;
    localparam logic [4:0] F5_SWAP = 5'b00001;
    localparam logic [4:0] F5_XOR  = 5'b00100;
    localparam logic [4:0] F5_OR   = 5'b01000;
    localparam logic [4:0] F5_AND  = 5'b01100;
    localparam logic [4:0] F5_MIN  = 5'b10000;
    localparam logic [4:0] F5_MAX  = 5'b10100;
    localparam logic [4:0] F5_MINU = 5'b11000;
    localparam logic [4:0] F5_MAXU = 5'b11100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_ACK,
        S_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [4:0]        f5_q;
    logic              dw_q;
    logic [XLEN-1:2]   addr_q;
    logic [XLEN-1:0]   src_q;
    logic              err_q;
    logic [XLEN-1:0]   old_q;
    logic [XLEN-1:0]   res_q;

    logic              f5_ok;
    logic              req_dw;
    logic              misaligned;
    logic              req_err;
    logic [31:0]       rd_word;
    logic [XLEN-1:0]   old_d;
    logic [XLEN-1:0]   b_s, a_u, b_u;
    logic              lt_s, lt_u;
    logic [XLEN-1:0]   new_val;
    logic [XLEN-1:0]   wdata;
    logic              is_lr, is_sc, resv_hit;

`ifdef AMO_LRSC_EN
    localparam logic [4:0] F5_LR = 5'b00010;
    localparam logic [4:0] F5_SC = 5'b00011;

    logic              resv_v;
    logic [XLEN-1:3]   resv_a;
    logic              lr_done;
    logic [XLEN-1:3]   kill_a;
    logic              unused_snp_lo;

    assign is_lr    = (f5_q == F5_LR);
    assign is_sc    = (f5_q == F5_SC);
    assign resv_hit = resv_v && (resv_a == addr_q[XLEN-1:3]);
    assign lr_done  = (state_q == S_RD) && !err_q && is_lr && b_ack;
    // A snoop racing the completing LR must be compared against the new granule
    assign kill_a   = lr_done ? addr_q[XLEN-1:3] : resv_a;
    assign unused_snp_lo = ^snp_addr[2:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resv_v <= 1'b0;
            resv_a <= '0;
        end else begin
            if (lr_done) begin
                resv_v <= 1'b1;
                resv_a <= addr_q[XLEN-1:3];
            end
            if ((state_q == S_RD) && !err_q && is_sc)
                resv_v <= 1'b0;
            if ((state_q == S_WR) && b_ack && !is_sc && (addr_q[XLEN-1:3] == resv_a))
                resv_v <= 1'b0;
            if (snp_wr && (snp_addr[XLEN-1:3] == kill_a))
                resv_v <= 1'b0;
        end
    end
`else
    logic unused_snp;

    assign is_lr      = 1'b0;
    assign is_sc      = 1'b0;
    assign resv_hit   = 1'b0;
    assign unused_snp = ^{snp_wr, snp_addr};
`endif

    always_comb begin
        f5_ok = 1'b0;
        case (amo_funct5)
            F5_ADD, F5_SWAP, F5_XOR, F5_OR, F5_AND,
            F5_MIN, F5_MAX, F5_MINU, F5_MAXU: f5_ok = 1'b1;
`ifdef AMO_LRSC_EN
            F5_LR, F5_SC: f5_ok = 1'b1;
`endif
            default: f5_ok = 1'b0;
        endcase
    end

    assign req_dw     = (amo_funct3 == 3'b011);
    assign misaligned = req_dw ? (amo_addr[2:0] != 3'b000) : (amo_addr[1:0] != 2'b00);
    assign req_err    = !f5_ok || !((amo_funct3 == 3'b010) || req_dw) || misaligned;

    assign rd_word = addr_q[2] ? b_data_r[63:32] : b_data_r[31:0];
    assign old_d   = dw_q ? b_data_r : {{(XLEN-32){rd_word[31]}}, rd_word};

    // old_q is already sign-extended for W, so only the operand sides need widening
    always_comb begin
        b_s     = dw_q ? src_q : {{(XLEN-32){src_q[31]}}, src_q[31:0]};
        a_u     = dw_q ? old_q : {{(XLEN-32){1'b0}}, old_q[31:0]};
        b_u     = dw_q ? src_q : {{(XLEN-32){1'b0}}, src_q[31:0]};
        lt_s    = $signed(old_q) < $signed(b_s);
        lt_u    = a_u < b_u;
        new_val = src_q;
        case (f5_q)
            F5_ADD:  new_val = old_q + src_q;
            F5_XOR:  new_val = old_q ^ src_q;
            F5_AND:  new_val = old_q & src_q;
            F5_OR:   new_val = old_q | src_q;
            F5_MIN:  new_val = lt_s ? old_q : src_q;
            F5_MAX:  new_val = lt_s ? src_q : old_q;
            F5_MINU: new_val = lt_u ? old_q : src_q;
            F5_MAXU: new_val = lt_u ? src_q : old_q;
            default: new_val = src_q;
        endcase
    end

    assign wdata = dw_q ? new_val : {new_val[31:0], new_val[31:0]};

    always_comb begin
        state_d = state_q;
        b_rd    = 1'b0;
        b_wr    = 1'b0;
        case (state_q)
            S_IDLE: if (amo_req) state_d = S_RD;
            S_RD: begin
                if (err_q) begin
                    state_d = S_ACK;
                end else if (is_sc) begin
                    state_d = resv_hit ? S_WR : S_ACK;
                end else begin
                    b_rd = 1'b1;
                    if (b_ack) state_d = is_lr ? S_ACK : S_WR;
                end
            end
            S_WR: begin
                b_wr = 1'b1;
                if (b_ack) state_d = S_ACK;
            end
            S_ACK:   state_d = S_DRAIN;
            S_DRAIN: if (!amo_req) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            f5_q    <= '0;
            dw_q    <= 1'b0;
            addr_q  <= '0;
            src_q   <= '0;
            err_q   <= 1'b0;
            old_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == S_IDLE) && amo_req) begin
                f5_q   <= amo_funct5;
                dw_q   <= req_dw;
                addr_q <= amo_addr[XLEN-1:2];
                src_q  <= amo_src;
                err_q  <= req_err;
                res_q  <= '0;
            end
            if ((state_q == S_RD) && !err_q) begin
                if (is_sc) begin
                    res_q <= {{(XLEN-1){1'b0}}, !resv_hit};
                end else if (b_ack) begin
                    old_q <= old_d;
                    res_q <= old_d;
                end
            end
        end
    end

    assign b_addr   = {addr_q[XLEN-1:3], 3'b000};
    assign b_data_w = (state_q == S_WR) ? wdata : '0;
    assign b_be     = (state_q != S_WR) ? 8'h00 :
                      dw_q              ? 8'hFF :
                      addr_q[2]         ? 8'hF0 : 8'h0F;
    assign amo_ack  = (state_q == S_ACK);
    assign amo_rd   = amo_ack ? res_q : '0;
    assign amo_err  = amo_ack && err_q;

endmodule

// File: tb/tb_amo_unit.sv
// tb/tb_amo_unit.sv - scoreboard bench for amo_unit with a byte-lane memory model
module tb_amo_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        amo_req = 1'b0;
    logic [4:0]  amo_funct5 = '0;
    logic [2:0]  amo_funct3 = '0;
    logic [63:0] amo_addr = '0;
    logic [63:0] amo_src = '0;
    logic [63:0] amo_rd;
    logic        amo_ack;
    logic        amo_err;
    logic [63:0] b_addr;
    logic        b_rd;
    logic        b_wr;
    logic [7:0]  b_be;
    logic [63:0] b_data_w;
    logic [63:0] b_data_r;
    logic        b_ack;
    logic        snp_wr = 1'b0;
    logic [63:0] snp_addr = '0;

    always #5 clk = ~clk;

    amo_unit dut (
        .clk(clk), .rst_n(rst_n), .amo_req(amo_req), .amo_funct5(amo_funct5),
        .amo_funct3(amo_funct3), .amo_addr(amo_addr), .amo_src(amo_src),
        .amo_rd(amo_rd), .amo_ack(amo_ack), .amo_err(amo_err), .b_addr(b_addr),
        .b_rd(b_rd), .b_wr(b_wr), .b_be(b_be), .b_data_w(b_data_w),
        .b_data_r(b_data_r), .b_ack(b_ack), .snp_wr(snp_wr), .snp_addr(snp_addr)
    );

    localparam logic [4:0] ADD = 5'b00000, SWAP = 5'b00001, LR = 5'b00010, SC = 5'b00011;
    localparam logic [4:0] XOR_ = 5'b00100, OR_ = 5'b01000, AND_ = 5'b01100;
    localparam logic [4:0] MIN = 5'b10000, MAX = 5'b10100, MINU = 5'b11000, MAXU = 5'b11100;
    localparam logic [2:0] W = 3'b010, D = 3'b011;

    typedef struct {
        logic [63:0] rd;
        logic        err;
        int          nrd;
        int          nwr;
        int          lat;
        int          start;
    } exp_t;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  be;
    } wr_t;

    exp_t        exp_q[$];
    wr_t         wr_q[$];
    logic [63:0] mem [0:2047];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          bus_delay = 0;
    int          nrd_seen = 0;
    int          nwr_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Bus responder: acks one cycle after it sees a strobe, plus bus_delay extra cycles
    logic        bm_wr;
    logic [63:0] bm_a;
    logic        bm_abort;
    wr_t         bm_w;

    initial begin
        b_ack = 1'b0;
        b_data_r = '0;
        forever begin
            @(negedge clk);
            b_ack = 1'b0;
            if (rst_n && (b_rd || b_wr)) begin
                bm_wr = b_wr;
                bm_a = b_addr;
                bm_abort = 1'b0;
                for (int k = 0; k < 1 + bus_delay; k++) begin
                    @(negedge clk);
                    if (!rst_n) begin
                        bm_abort = 1'b1;
                        break;
                    end
                    check("strobe_hold", {62'b0, b_rd, b_wr}, {62'b0, !bm_wr, bm_wr});
                    check("addr_hold", b_addr, bm_a);
                end
                if (!bm_abort) begin
                    if (bm_wr) begin
                        nwr_seen++;
                        if (wr_q.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL unexpected_write: addr %h data %h", b_addr, b_data_w);
                        end else begin
                            bm_w = wr_q.pop_front();
                            check("wr_addr", b_addr, bm_w.addr);
                            check("wr_data", b_data_w, bm_w.data);
                            check("wr_be", {56'b0, b_be}, {56'b0, bm_w.be});
                        end
                        for (int j = 0; j < 8; j++)
                            if (b_be[j]) mem[b_addr[13:3]][j*8 +: 8] = b_data_w[j*8 +: 8];
                    end else begin
                        nrd_seen++;
                        b_data_r = mem[b_addr[13:3]];
                    end
                    b_ack = 1'b1;
                end
            end
        end
    end

    exp_t me;

    always @(negedge clk) begin
        if (rst_n && amo_ack) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ack: amo_rd %h amo_err %b", amo_rd, amo_err);
            end else begin
                me = exp_q.pop_front();
                check("amo_rd", amo_rd, me.rd);
                check("amo_err", {63'b0, amo_err}, {63'b0, me.err});
                check("bus_reads", 64'(nrd_seen), 64'(me.nrd));
                check("bus_writes", 64'(nwr_seen), 64'(me.nwr));
                if (me.lat >= 0) check("latency", 64'(cyc - me.start), 64'(me.lat));
            end
            nrd_seen = 0;
            nwr_seen = 0;
        end
    end

    task automatic exp_wr(input logic [63:0] a, input logic [63:0] d, input logic [7:0] be);
        wr_t w;
        w.addr = a;
        w.data = d;
        w.be = be;
        wr_q.push_back(w);
    endtask

    task automatic run_op(input logic [4:0] f5, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] src, input logic [63:0] rd, input logic err,
                          input int nrd, input int nwr, input int lat, input int hold);
        exp_t e;
        logic got;
        @(negedge clk);
        amo_funct5 = f5;
        amo_funct3 = f3;
        amo_addr = a;
        amo_src = src;
        amo_req = 1'b1;
        e.rd = rd;
        e.err = err;
        e.nrd = nrd;
        e.nwr = nwr;
        e.lat = lat;
        e.start = cyc;
        exp_q.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (amo_ack) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ack_timeout: op %b addr %h no ack within 200 cycles", f5, a);
            exp_q.delete();
        end
        repeat (hold) @(negedge clk);
        amo_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic snoop(input logic [63:0] a);
        @(negedge clk);
        snp_wr = 1'b1;
        snp_addr = a;
        @(negedge clk);
        snp_wr = 1'b0;
    endtask

    logic seen;

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {59'b0, amo_ack, amo_err, b_rd, b_wr, 1'b0}, 64'd0);
        check("rst_amo_rd", amo_rd, 64'd0);
        check("rst_b_addr", b_addr, 64'd0);
        check("rst_b_be_data", b_data_w | {56'b0, b_be}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        mem[12'h200] = 64'd5;
        exp_wr(64'h1000, 64'd12, 8'hFF);
        run_op(ADD, D, 64'h1000, 64'd7, 64'd5, 1'b0, 1, 1, 5, 0);

        mem[12'h200] = 64'hFFFF_FFFE_0000_000C;
        exp_wr(64'h1000, 64'hFFFF_FFFE_FFFF_FFFE, 8'hF0);
        run_op(MIN, W, 64'h1004, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1, 1, 5, 0);

        run_op(SWAP, D, 64'h1003, 64'd9, 64'd0, 1'b1, 0, 0, 2, 0);
        run_op(ADD, W, 64'h1002, 64'd9, 64'd0, 1'b1, 0, 0, 2, 0);
        run_op(ADD, 3'b000, 64'h1000, 64'd9, 64'd0, 1'b1, 0, 0, 2, 0);
        run_op(5'b00101, D, 64'h1000, 64'd9, 64'd0, 1'b1, 0, 0, 2, 0);

        bus_delay = 3;
        mem[12'h201] = 64'hF0F0;
        exp_wr(64'h1008, 64'hF00F, 8'hFF);
        run_op(XOR_, D, 64'h1008, 64'hFF, 64'hF0F0, 1'b0, 1, 1, -1, 0);
        bus_delay = 0;

        mem[12'h202] = 64'h1234_5678_FFFF_00FF;
        exp_wr(64'h1010, 64'h0F0F_000F_0F0F_000F, 8'h0F);
        run_op(AND_, W, 64'h1010, 64'h0F0F_0F0F, 64'hFFFF_FFFF_FFFF_00FF, 1'b0, 1, 1, 5, 0);

        mem[12'h203] = 64'hAAAA_AAAA_FFFF_FFFF;
        exp_wr(64'h1018, 64'h0000_0001_0000_0001, 8'h0F);
        run_op(ADD, W, 64'h1018, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1, 1, 5, 0);

        mem[12'h204] = 64'h8000_0000_0000_0000;
        exp_wr(64'h1020, 64'h8000_0000_0000_0000, 8'hFF);
        run_op(MAXU, D, 64'h1020, 64'd1, 64'h8000_0000_0000_0000, 1'b0, 1, 1, 5, 0);
        exp_wr(64'h1020, 64'd1, 8'hFF);
        run_op(MAX, D, 64'h1020, 64'd1, 64'h8000_0000_0000_0000, 1'b0, 1, 1, 5, 0);

        mem[12'h205] = 64'h8000_0001_0000_0000;
        exp_wr(64'h1028, 64'h7FFF_FFFF_7FFF_FFFF, 8'hF0);
        run_op(MINU, W, 64'h102C, 64'hDEAD_BEEF_7FFF_FFFF, 64'hFFFF_FFFF_8000_0001, 1'b0, 1, 1, 5, 0);

        mem[12'h206] = 64'h0F;
        exp_wr(64'h1030, 64'hFF, 8'hFF);
        run_op(OR_, D, 64'h1030, 64'hF0, 64'h0F, 1'b0, 1, 1, 5, 0);

        // Request held well past the ack must not run a second time
        mem[12'h208] = 64'd100;
        exp_wr(64'h1040, 64'd101, 8'hFF);
        run_op(ADD, D, 64'h1040, 64'd1, 64'd100, 1'b0, 1, 1, 5, 4);

`ifdef AMO_LRSC_EN
        mem[12'h400] = 64'h55;
        run_op(LR, D, 64'h2000, 64'd0, 64'h55, 1'b0, 1, 0, 3, 0);
        exp_wr(64'h2000, 64'h66, 8'hFF);
        run_op(SC, D, 64'h2000, 64'h66, 64'd0, 1'b0, 0, 1, -1, 0);
        run_op(SC, D, 64'h2000, 64'h77, 64'd1, 1'b0, 0, 0, 2, 0);
        run_op(LR, D, 64'h2000, 64'd0, 64'h66, 1'b0, 1, 0, 3, 0);
        snoop(64'h2004);
        run_op(SC, D, 64'h2000, 64'h77, 64'd1, 1'b0, 0, 0, 2, 0);
        run_op(LR, D, 64'h2000, 64'd0, 64'h66, 1'b0, 1, 0, 3, 0);
        exp_wr(64'h2000, 64'h67, 8'hFF);
        run_op(ADD, D, 64'h2000, 64'd1, 64'h66, 1'b0, 1, 1, 5, 0);
        run_op(SC, D, 64'h2000, 64'h77, 64'd1, 1'b0, 0, 0, 2, 0);
        run_op(LR, D, 64'h2000, 64'd0, 64'h67, 1'b0, 1, 0, 3, 0);
`else
        snoop(64'h2000);
        run_op(LR, D, 64'h2000, 64'd0, 64'd0, 1'b1, 0, 0, 2, 0);
        run_op(SC, D, 64'h2000, 64'h77, 64'd0, 1'b1, 0, 0, 2, 0);
`endif

        // Reset while the read strobe is up must drop it at once
        bus_delay = 3;
        @(negedge clk);
        amo_funct5 = ADD;
        amo_funct3 = D;
        amo_addr = 64'h1038;
        amo_src = 64'd1;
        amo_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b_rd) begin
                seen = 1'b1;
                break;
            end
        end
        check("rd_before_reset", {63'b0, seen}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("reset_drops_strobes", {62'b0, b_rd, b_wr}, 64'd0);
        check("reset_no_ack", {63'b0, amo_ack}, 64'd0);
        amo_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus_delay = 0;
        nrd_seen = 0;
        nwr_seen = 0;
        @(negedge clk);

        mem[12'h209] = 64'hAB;
        exp_wr(64'h1048, 64'hCD, 8'hFF);
        run_op(SWAP, D, 64'h1048, 64'hCD, 64'hAB, 1'b0, 1, 1, 5, 0);
`ifdef AMO_LRSC_EN
        run_op(SC, D, 64'h2000, 64'h77, 64'd1, 1'b0, 0, 0, 2, 0);
`endif

        repeat (4) @(negedge clk);
        check("exp_left", 64'(exp_q.size()), 64'd0);
        check("wr_left", 64'(wr_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
